// File: rtl/pc_pkg.sv
// Shared definitions for the next-PC generator: PC width, flow-op encodings
// and the RUN/HALTED state type.
package pc_pkg;

  localparam int PC_W = 5;

  localparam logic [2:0] OP_SEQ  = 3'd0;
  localparam logic [2:0] OP_BR   = 3'd1;
  localparam logic [2:0] OP_JMP  = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_HALT = 3'd5;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

endpackage

// File: rtl/pc_next_gen_if.sv
// Bundle between the control decoder / PC register and the next-PC generator.
// The slave modport is the generator side; master is the driving side.
interface pc_next_gen_if #(
  parameter int PC_W      = 5,
  parameter int RAS_DEPTH = 4
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [PC_W-1:0]  pc_cur;
  logic             stall;
  logic [2:0]       op;
  logic             cond;
  logic [PC_W-1:0]  offset;
  logic [PC_W-1:0]  target;
  logic [PC_W-1:0]  pc_next;
  logic             halted;
  logic [CNT_W-1:0] ras_count;
  logic             ras_overflow;
  logic             ras_underflow;

  modport slave (
    input  pc_cur, stall, op, cond, offset, target,
    output pc_next, halted, ras_count, ras_overflow, ras_underflow
  );

  modport master (
    output pc_cur, stall, op, cond, offset, target,
    input  pc_next, halted, ras_count, ras_overflow, ras_underflow
  );

endinterface

// File: rtl/pc_next_gen_ras_stack.sv
// Circular return-address stack. When full, a push overwrites the oldest
// entry (which is exactly the slot the write pointer has wrapped onto).
module ras_stack #(
  parameter int PC_W      = 5,
  parameter int RAS_DEPTH = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               push_i,
  input  logic                               pop_i,
  input  logic [PC_W-1:0]                    push_data_i,
  output logic [PC_W-1:0]                    top_o,
  output logic [$clog2(RAS_DEPTH+1)-1:0]     count_o,
  output logic                               full_o,
  output logic                               empty_o
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign full_o  = (count_q == CNT_MAX);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  // Pointer addresses the next free slot, so the top lives one below it.
  assign top_o   = mem_q[ptr_q - PTR_W'(1)];

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (push_i) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (!full_o) count_d = count_q + CNT_W'(1);
    end else if (pop_i && !empty_o) begin
      ptr_d   = ptr_q - PTR_W'(1);
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_i) mem_q[ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/pc_next_gen.sv
// Next-PC generator: op mux, PC adder and RUN/HALTED FSM around a
// return-address stack. pc_next is purely combinational from the inputs.
module pc_next_gen
  import pc_pkg::*;
#(
  parameter int PC_W      = pc_pkg::PC_W,
  parameter int RAS_DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset,
  pc_next_gen_if.slave  bus
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  state_e          state_q, state_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;
  logic            active;
  logic            push_en, pop_en, ret_empty;
  logic            ras_full, ras_empty;
  logic [PC_W-1:0] ras_top;
  logic [PC_W-1:0] inc, br_tgt;
  logic [CNT_W-1:0] ras_cnt;

  assign inc    = bus.pc_cur + PC_W'(1);
  // Same-width add wraps modulo 2^PC_W, which equals sign-extended addition.
  assign br_tgt = inc + bus.offset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN && !bus.stall && bus.op == OP_HALT) state_d = ST_HALTED;
  end

  always_comb begin
    active      = (state_q == ST_RUN) && !bus.stall;
    push_en     = active && (bus.op == OP_CALL);
    pop_en      = active && (bus.op == OP_RET) && !ras_empty;
    ret_empty   = active && (bus.op == OP_RET) && ras_empty;
    overflow_d  = overflow_q | (push_en & ras_full);
    underflow_d = underflow_q | ret_empty;
  end

  always_comb begin
    bus.pc_next = inc;
    if (reset) begin
      bus.pc_next = '0;
    end else if (state_q == ST_HALTED || bus.stall) begin
      bus.pc_next = bus.pc_cur;
    end else begin
      case (bus.op)
        OP_BR:   bus.pc_next = bus.cond ? br_tgt : inc;
        OP_JMP:  bus.pc_next = bus.target;
        OP_CALL: bus.pc_next = bus.target;
        OP_RET:  bus.pc_next = ras_empty ? inc : ras_top;
        OP_HALT: bus.pc_next = bus.pc_cur;
        default: bus.pc_next = inc;
      endcase
    end
  end

  assign bus.halted        = (state_q == ST_HALTED);
  assign bus.ras_count     = ras_cnt;
  assign bus.ras_overflow  = overflow_q;
  assign bus.ras_underflow = underflow_q;

  ras_stack #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push_en),
    .pop_i       (pop_en),
    .push_data_i (inc),
    .top_o       (ras_top),
    .count_o     (ras_cnt),
    .full_o      (ras_full),
    .empty_o     (ras_empty)
  );

endmodule

// File: tb/tb_pc_next_gen.sv
// Directed bench for pc_next_gen: flow ops, RAS nesting/overflow/underflow,
// stall and halt, with hand-computed expected values.
module tb_pc_next_gen;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  pc_next_gen_if #(.PC_W(5), .RAS_DEPTH(4)) bus ();

  pc_next_gen #(.PC_W(5), .RAS_DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [4:0] pc,
                       input logic cnd, input logic [4:0] off, input logic [4:0] tgt);
    bus.op     = op;
    bus.pc_cur = pc;
    bus.cond   = cnd;
    bus.offset = off;
    bus.target = tgt;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.stall = 1'b0;
    drive(3'd0, 5'd5, 1'b0, 5'd0, 5'd0);
    check_eq("rst_pc_next", 32'(bus.pc_next), 0);
    check_eq("rst_halted", 32'(bus.halted), 0);
    check_eq("rst_count", 32'(bus.ras_count), 0);
    check_eq("rst_ovf", 32'(bus.ras_overflow), 0);
    check_eq("rst_unf", 32'(bus.ras_underflow), 0);
    tick();
    tick();
    reset = 1'b0;
    #1;

    drive(3'd0, 5'd5, 1'b0, 5'd0, 5'd0);
    check_eq("seq_5", 32'(bus.pc_next), 6);
    drive(3'd0, 5'd31, 1'b0, 5'd0, 5'd0);
    check_eq("seq_wrap", 32'(bus.pc_next), 0);
    drive(3'd7, 5'd9, 1'b1, 5'd3, 5'd20);
    check_eq("op7_seq", 32'(bus.pc_next), 10);
    drive(3'd1, 5'd10, 1'b1, 5'b11101, 5'd0);
    check_eq("br_taken", 32'(bus.pc_next), 8);
    drive(3'd1, 5'd10, 1'b0, 5'b11101, 5'd0);
    check_eq("br_not_taken", 32'(bus.pc_next), 11);
    drive(3'd2, 5'd10, 1'b0, 5'd0, 5'd20);
    check_eq("jmp", 32'(bus.pc_next), 20);
    tick();
    check_eq("jmp_count", 32'(bus.ras_count), 0);
    check_eq("run_halted", 32'(bus.halted), 0);

    // nested calls and returns
    drive(3'd3, 5'd3, 1'b0, 5'd0, 5'd12);
    check_eq("call1", 32'(bus.pc_next), 12);
    tick();
    check_eq("call1_count", 32'(bus.ras_count), 1);
    drive(3'd3, 5'd14, 1'b0, 5'd0, 5'd25);
    check_eq("call2", 32'(bus.pc_next), 25);
    tick();
    check_eq("call2_count", 32'(bus.ras_count), 2);
    drive(3'd4, 5'd26, 1'b0, 5'd0, 5'd0);
    check_eq("ret1", 32'(bus.pc_next), 15);
    tick();
    check_eq("ret1_count", 32'(bus.ras_count), 1);
    drive(3'd4, 5'd16, 1'b0, 5'd0, 5'd0);
    check_eq("ret2", 32'(bus.pc_next), 4);
    tick();
    check_eq("ret2_count", 32'(bus.ras_count), 0);
    drive(3'd4, 5'd7, 1'b0, 5'd0, 5'd0);
    check_eq("ret_empty", 32'(bus.pc_next), 8);
    check_eq("unf_before", 32'(bus.ras_underflow), 0);
    tick();
    check_eq("unf_set", 32'(bus.ras_underflow), 1);
    check_eq("unf_count", 32'(bus.ras_count), 0);
    drive(3'd0, 5'd8, 1'b0, 5'd0, 5'd0);
    tick();
    check_eq("unf_sticky", 32'(bus.ras_underflow), 1);

    // overflow: five calls into a depth-4 stack
    for (int i = 0; i < 5; i++) begin
      drive(3'd3, 5'(i), 1'b0, 5'd0, 5'd20);
      tick();
      if (i == 3) begin
        check_eq("ovf_at_full", 32'(bus.ras_overflow), 0);
        check_eq("count_full", 32'(bus.ras_count), 4);
      end
    end
    check_eq("ovf_set", 32'(bus.ras_overflow), 1);
    check_eq("ovf_count", 32'(bus.ras_count), 4);
    for (int i = 0; i < 4; i++) begin
      drive(3'd4, 5'd20, 1'b0, 5'd0, 5'd0);
      check_eq($sformatf("ovf_ret%0d", i), 32'(bus.pc_next), 32'(5 - i));
      tick();
    end
    check_eq("ovf_drained", 32'(bus.ras_count), 0);

    // stall freezes the push
    bus.stall = 1'b1;
    drive(3'd3, 5'd9, 1'b0, 5'd0, 5'd30);
    check_eq("stall_pc", 32'(bus.pc_next), 9);
    tick();
    check_eq("stall_count", 32'(bus.ras_count), 0);
    bus.stall = 1'b0;
    #1;
    check_eq("unstall_pc", 32'(bus.pc_next), 30);
    tick();
    check_eq("unstall_count", 32'(bus.ras_count), 1);
    drive(3'd4, 5'd30, 1'b0, 5'd0, 5'd0);
    check_eq("unstall_ret", 32'(bus.pc_next), 10);
    tick();

    // halt is absorbing
    drive(3'd5, 5'd17, 1'b0, 5'd0, 5'd0);
    check_eq("halt_pc", 32'(bus.pc_next), 17);
    check_eq("halt_pre", 32'(bus.halted), 0);
    tick();
    check_eq("halted", 32'(bus.halted), 1);
    drive(3'd2, 5'd17, 1'b0, 5'd0, 5'd0);
    check_eq("halt_jmp", 32'(bus.pc_next), 17);
    drive(3'd3, 5'd18, 1'b0, 5'd0, 5'd3);
    check_eq("halt_call", 32'(bus.pc_next), 18);
    tick();
    check_eq("halt_count", 32'(bus.ras_count), 0);
    check_eq("halt_still", 32'(bus.halted), 1);
    drive(3'd4, 5'd18, 1'b0, 5'd0, 5'd0);
    tick();
    check_eq("halt_flags_ovf", 32'(bus.ras_overflow), 1);
    check_eq("halt_flags_unf", 32'(bus.ras_underflow), 1);

    // asynchronous reset between edges
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_eq("arst_halted", 32'(bus.halted), 0);
    check_eq("arst_pc_next", 32'(bus.pc_next), 0);
    check_eq("arst_ovf", 32'(bus.ras_overflow), 0);
    check_eq("arst_unf", 32'(bus.ras_underflow), 0);
    tick();
    reset = 1'b0;
    drive(3'd0, 5'd5, 1'b0, 5'd0, 5'd0);
    check_eq("post_rst_seq", 32'(bus.pc_next), 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
